// File: rtl/vga_timing_pkg.sv
// Shared timing constants, count widths and the raster bundle type for the VGA path.
// Default geometry is 800x600 @ 60 Hz on a 40 MHz pixel clock.
package vga_timing_pkg;

  localparam int H_ACTIVE = 800;
  localparam int H_FP     = 40;
  localparam int H_SYNC   = 128;
  localparam int H_BP     = 88;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 600;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 4;
  localparam int V_BP     = 23;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int HCNT_W = 11;
  localparam int VCNT_W = 10;
  localparam int FCNT_W = 16;

  typedef struct packed {
    logic [HCNT_W-1:0] hcount;
    logic [VCNT_W-1:0] vcount;
    logic              hblnk;
    logic              vblnk;
    logic              hsync;
    logic              vsync;
  } vga_timing_t;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing bus from the raster generator to the draw stages; frame_cnt exists only
// when VGA_FRAME_CNT_EN is defined.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic              ce;
  logic [HCNT_W-1:0] hcount;
  logic [VCNT_W-1:0] vcount;
  logic              hblnk;
  logic              vblnk;
  logic              hsync;
  logic              vsync;
  logic              frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [FCNT_W-1:0] frame_cnt;

  modport master (input ce, output hcount, output vcount, output hblnk, output vblnk,
                  output hsync, output vsync, output frame_start, output frame_cnt);
  modport slave  (output ce, input hcount, input vcount, input hblnk, input vblnk,
                  input hsync, input vsync, input frame_start, input frame_cnt);
`else
  modport master (input ce, output hcount, output vcount, output hblnk, output vblnk,
                  output hsync, output vsync, output frame_start);
  modport slave  (output ce, input hcount, input vcount, input hblnk, input vblnk,
                  input hsync, input vsync, input frame_start);
`endif

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered blank/sync flags that
// are derived from the next count, so they always line up with the presented count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE,
  parameter int FP     = H_FP,
  parameter int SYNC   = H_SYNC,
  parameter int BP     = H_BP,
  parameter int W      = HCNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_step,
  output logic [W-1:0] o_count,
  output logic         o_blank,
  output logic         o_sync,
  output logic         o_wrap
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  localparam logic [W-1:0] L_LAST        = W'(TOTAL - 1);
  localparam logic [W-1:0] L_ONE         = W'(1);
  localparam logic [W-1:0] L_BLANK_START = W'(ACTIVE);
  localparam logic [W-1:0] L_SYNC_START  = W'(ACTIVE + FP);
  localparam logic [W-1:0] L_SYNC_LAST   = W'(ACTIVE + FP + SYNC - 1);

  logic [W-1:0] r_count;
  logic [W-1:0] w_count_nxt;
  logic         r_blank;
  logic         r_sync;

  // next position: hold, step, or wrap from the last position
  always_comb begin
    w_count_nxt = r_count;
    if (i_step) begin
      if (r_count == L_LAST) begin
        w_count_nxt = {W{1'b0}};
      end else begin
        w_count_nxt = r_count + L_ONE;
      end
    end else begin
      w_count_nxt = r_count;
    end
  end

  // position and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= {W{1'b0}};
      r_blank <= 1'b0;
      r_sync  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_blank <= (w_count_nxt >= L_BLANK_START);
      r_sync  <= (w_count_nxt >= L_SYNC_START) && (w_count_nxt <= L_SYNC_LAST);
    end
  end

  assign o_count = r_count;
  assign o_blank = r_blank;
  assign o_sync  = r_sync;
  assign o_wrap  = (r_count == L_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: chains a horizontal and a vertical axis counter and flags
// the double wrap back to (0,0); VGA_FRAME_CNT_EN adds a 16-bit frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int P_H_ACTIVE = H_ACTIVE,
  parameter int P_H_FP     = H_FP,
  parameter int P_H_SYNC   = H_SYNC,
  parameter int P_H_BP     = H_BP,
  parameter int P_V_ACTIVE = V_ACTIVE,
  parameter int P_V_FP     = V_FP,
  parameter int P_V_SYNC   = V_SYNC,
  parameter int P_V_BP     = V_BP
) (
  input logic              clk,
  input logic              rst,
  vga_timing_gen_if.master bus
);

  logic [HCNT_W-1:0] w_hcount;
  logic [VCNT_W-1:0] w_vcount;
  logic              w_hblnk;
  logic              w_vblnk;
  logic              w_hsync;
  logic              w_vsync;
  logic              w_h_wrap;
  logic              w_v_wrap;
  logic              w_v_step;
  logic              w_frame_wrap;
  logic              r_frame_start;
  vga_timing_t       w_timing;

  // the line counter only steps on a ce-qualified end of line
  assign w_v_step     = bus.ce & w_h_wrap;
  assign w_frame_wrap = w_v_step & w_v_wrap;

  vga_axis_counter #(
    .ACTIVE (P_H_ACTIVE),
    .FP     (P_H_FP),
    .SYNC   (P_H_SYNC),
    .BP     (P_H_BP),
    .W      (HCNT_W)
  ) u_h_axis (
    .clk     (clk),
    .rst     (rst),
    .i_step  (bus.ce),
    .o_count (w_hcount),
    .o_blank (w_hblnk),
    .o_sync  (w_hsync),
    .o_wrap  (w_h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE (P_V_ACTIVE),
    .FP     (P_V_FP),
    .SYNC   (P_V_SYNC),
    .BP     (P_V_BP),
    .W      (VCNT_W)
  ) u_v_axis (
    .clk     (clk),
    .rst     (rst),
    .i_step  (w_v_step),
    .o_count (w_vcount),
    .o_blank (w_vblnk),
    .o_sync  (w_vsync),
    .o_wrap  (w_v_wrap)
  );

  // frame_start marks only the wrap into (0,0), never the post-reset (0,0)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_frame_wrap;
    end
  end

  assign w_timing = '{hcount: w_hcount, vcount: w_vcount, hblnk: w_hblnk,
                      vblnk: w_vblnk, hsync: w_hsync, vsync: w_vsync};

  assign bus.hcount      = w_timing.hcount;
  assign bus.vcount      = w_timing.vcount;
  assign bus.hblnk       = w_timing.hblnk;
  assign bus.vblnk       = w_timing.vblnk;
  assign bus.hsync       = w_timing.hsync;
  assign bus.vsync       = w_timing.vsync;
  assign bus.frame_start = r_frame_start;

`ifdef VGA_FRAME_CNT_EN
  logic [FCNT_W-1:0] r_frame_cnt;

  // frame counter steps together with the frame_start pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt <= {FCNT_W{1'b0}};
    end else if (w_frame_wrap) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end else begin
      r_frame_cnt <= r_frame_cnt;
    end
  end

  assign bus.frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: a default-geometry instance for line-level timing and a shrunken-geometry
// instance for whole-frame behaviour, both compared cycle by cycle to a position model.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int SH_A = 16, SH_F = 2, SH_S = 4, SH_B = 3;
  localparam int SV_A = 10, SV_F = 1, SV_S = 2, SV_B = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_timing_gen_if if_big ();
  vga_timing_gen_if if_sml ();

  vga_timing_gen u_big (.clk(clk), .rst(rst), .bus(if_big));
  vga_timing_gen #(
    .P_H_ACTIVE(SH_A), .P_H_FP(SH_F), .P_H_SYNC(SH_S), .P_H_BP(SH_B),
    .P_V_ACTIVE(SV_A), .P_V_FP(SV_F), .P_V_SYNC(SV_S), .P_V_BP(SV_B)
  ) u_sml (.clk(clk), .rst(rst), .bus(if_sml));

  int n_checks = 0;
  int n_errors = 0;
  int ha[2], hf[2], hs[2], ht[2], va[2], vf[2], vs[2], vt[2];
  int m_hc[2], m_vc[2], m_fs[2], m_fcnt[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: a raster position walking a ht x vt grid one pixel per enabled clock.
  task automatic model_step(input int d, input logic r, input logic ce);
    if (r) begin
      m_hc[d] = 0; m_vc[d] = 0; m_fs[d] = 0; m_fcnt[d] = 0;
    end else if (ce) begin
      m_fs[d] = (m_hc[d] == ht[d] - 1 && m_vc[d] == vt[d] - 1) ? 1 : 0;
      if (m_fs[d] == 1) m_fcnt[d] = (m_fcnt[d] + 1) % 65536;
      m_hc[d] = m_hc[d] + 1;
      if (m_hc[d] == ht[d]) begin
        m_hc[d] = 0;
        m_vc[d] = (m_vc[d] + 1) % vt[d];
      end
    end else begin
      m_fs[d] = 0;
    end
  endtask

  task automatic check_dut(input int d);
    string p;
    logic [31:0] o_hc, o_vc, o_fc;
    logic o_hb, o_vb, o_hs, o_vs, o_fs;
    o_fc = 32'd0;
    if (d == 0) begin
      p = "big";
      o_hc = 32'(if_big.hcount); o_vc = 32'(if_big.vcount);
      o_hb = if_big.hblnk; o_vb = if_big.vblnk; o_hs = if_big.hsync;
      o_vs = if_big.vsync; o_fs = if_big.frame_start;
`ifdef VGA_FRAME_CNT_EN
      o_fc = 32'(if_big.frame_cnt);
`endif
    end else begin
      p = "sml";
      o_hc = 32'(if_sml.hcount); o_vc = 32'(if_sml.vcount);
      o_hb = if_sml.hblnk; o_vb = if_sml.vblnk; o_hs = if_sml.hsync;
      o_vs = if_sml.vsync; o_fs = if_sml.frame_start;
`ifdef VGA_FRAME_CNT_EN
      o_fc = 32'(if_sml.frame_cnt);
`endif
    end
    chk({p, ".hcount"}, o_hc, m_hc[d]);
    chk({p, ".vcount"}, o_vc, m_vc[d]);
    chk({p, ".hblnk"}, 32'(o_hb), (m_hc[d] >= ha[d]) ? 1 : 0);
    chk({p, ".vblnk"}, 32'(o_vb), (m_vc[d] >= va[d]) ? 1 : 0);
    chk({p, ".hsync"}, 32'(o_hs),
        (m_hc[d] >= ha[d] + hf[d] && m_hc[d] < ha[d] + hf[d] + hs[d]) ? 1 : 0);
    chk({p, ".vsync"}, 32'(o_vs),
        (m_vc[d] >= va[d] + vf[d] && m_vc[d] < va[d] + vf[d] + vs[d]) ? 1 : 0);
    chk({p, ".frame_start"}, 32'(o_fs), m_fs[d]);
`ifdef VGA_FRAME_CNT_EN
    chk({p, ".frame_cnt"}, o_fc, m_fcnt[d]);
`else
    o_fc = 32'd0;
`endif
  endtask

  task automatic tick(input logic r, input logic ce0, input logic ce1);
    rst = r; if_big.ce = ce0; if_sml.ce = ce1;
    @(posedge clk);
    #1;
    model_step(0, r, ce0);
    model_step(1, r, ce1);
    check_dut(0);
    check_dut(1);
  endtask

  initial begin
    int hs_cnt, hs_rise, hs_fall, n_fs, last_fs, vs_acc, cyc, lat;
    logic prev_hs, prev_fs, c;
    ha = '{H_ACTIVE, SH_A}; hf = '{H_FP, SH_F}; hs = '{H_SYNC, SH_S};
    ht = '{H_TOTAL, SH_A + SH_F + SH_S + SH_B};
    va = '{V_ACTIVE, SV_A}; vf = '{V_FP, SV_F}; vs = '{V_SYNC, SV_S};
    vt = '{V_TOTAL, SV_A + SV_F + SV_S + SV_B};
    if_big.ce = 1'b0; if_sml.ce = 1'b0;

    // reset state, with ce high to show rst wins
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1);

    // three full default lines; many shrunken frames
    hs_cnt = 0; hs_rise = -1; hs_fall = -1; prev_hs = 1'b0;
    n_fs = 0; last_fs = 0; vs_acc = 0;
    for (int i = 1; i <= 3 * H_TOTAL; i++) begin
      tick(1'b0, 1'b1, 1'b1);
      if (i <= H_TOTAL) begin
        if (if_big.hsync) hs_cnt++;
        if (if_big.hsync && !prev_hs && hs_rise < 0) hs_rise = int'(if_big.hcount);
        if (!if_big.hsync && prev_hs && hs_fall < 0) hs_fall = int'(if_big.hcount);
      end
      prev_hs = if_big.hsync;
      if (if_sml.frame_start) begin
        if (n_fs > 0) begin
          chk("sml.frame_period", i - last_fs, ht[1] * vt[1]);
          chk("sml.vsync_per_frame", vs_acc, SV_S * ht[1]);
        end else begin
          chk("sml.first_frame_start", i, ht[1] * vt[1]);
        end
        n_fs++; last_fs = i; vs_acc = 0;
      end
      if (if_sml.vsync) vs_acc++;
    end
    chk("big.hsync_width", hs_cnt, H_SYNC);
    chk("big.hsync_rise_at", hs_rise, H_ACTIVE + H_FP);
    chk("big.hsync_fall_at", hs_fall, H_ACTIVE + H_FP + H_SYNC);
    chk("big.vcount_after_3_lines", 32'(if_big.vcount), 3);
    chk("sml.frames_seen", n_fs, (3 * H_TOTAL) / (ht[1] * vt[1]));

    // ce toggling every cycle; frame_start must stay one clock wide
    prev_fs = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      c = (i % 2 == 0) ? 1'b1 : 1'b0;
      tick(1'b0, c, c);
      if (if_sml.frame_start) chk("sml.frame_start_single", 32'(prev_fs), 0);
      prev_fs = if_sml.frame_start;
    end

    // random pixel enables
    for (int i = 0; i < 3000; i++) begin
      tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // reset mid-line: walk the default instance to hcount=500 (bounded)
    for (int i = 0; i < H_TOTAL && m_hc[0] != 500; i++) tick(1'b0, 1'b1, 1'b1);
    chk("big.reached_500", 32'(if_big.hcount), 500);
    tick(1'b1, 1'b1, 1'b1);
    chk("big.rst_hcount", 32'(if_big.hcount), 0);
    chk("big.rst_vcount", 32'(if_big.vcount), 0);

    // first frame_start comes a full frame of enabled cycles after reset
    lat = -1;
    for (cyc = 1; cyc <= 2 * ht[1] * vt[1] && lat < 0; cyc++) begin
      tick(1'b0, 1'b1, 1'b1);
      if (if_sml.frame_start) lat = cyc;
    end
    chk("sml.rst_to_frame_start", lat, ht[1] * vt[1]);

`ifdef VGA_FRAME_CNT_EN
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3 * ht[1] * vt[1]; i++) tick(1'b0, 1'b1, 1'b1);
    chk("sml.frame_cnt_after_3", 32'(if_sml.frame_cnt), 3);
    tick(1'b1, 1'b1, 1'b1);
    chk("sml.frame_cnt_reset", 32'(if_sml.frame_cnt), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
